// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and access sequencer for the single-port
// synchronous data RAM. Requester 0 is the processor load/store port and
// requester 1 is a secondary master (DMA / debug loader). One access is in
// flight at a time. RAM address, write data and write enable come from
// registers. Read data or a write ack is returned to the owner as a
// one-cycle pulse.
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          rsp0_valid,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_READ   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic          owner_q, owner_d;
  logic          op_we_q, op_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_data_q, ram_data_d;
  logic          ram_wren_q, ram_wren_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

  logic grant_phase;
  logic grant0;
  logic grant1;
  logic accept;
  logic winner;

  // Grant decode: only in IDLE/RESP, never during reset; rr_ptr breaks ties.
  always_comb begin
    grant_phase = Resetn && ((state_q == ST_IDLE) || (state_q == ST_RESP));
    grant0      = grant_phase && req0_valid && (!req1_valid || !rr_ptr_q);
    grant1      = grant_phase && req1_valid && (!req0_valid ||  rr_ptr_q);
    accept      = grant0 || grant1;
    winner      = grant1;
  end

  // Sequencer next-state: load RAM lines on accept, then walk ACCESS -> (READ) -> RESP.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    op_we_d     = op_we_q;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    ram_wren_d  = ram_wren_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          state_d    = ST_ACCESS;
          ram_addr_d = winner ? req1_addr  : req0_addr;
          ram_data_d = winner ? req1_wdata : req0_wdata;
          ram_wren_d = winner ? req1_we    : req0_we;
          op_we_d    = winner ? req1_we    : req0_we;
          owner_d    = winner;
          // The loser gets priority next time, bounding its wait to one access.
          rr_ptr_d   = ~winner;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // The RAM samples address/write at the end of this cycle.
        ram_wren_d = 1'b0;
        if (op_we_q) begin
          state_d     = ST_RESP;
          rsp_rdata_d = '0;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        rsp_rdata_d = ram_q;
        state_d     = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; async reset drops any in-flight access and write enable at once.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 1'b0;
      owner_q     <= 1'b0;
      op_we_q     <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_wren_q  <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      op_we_q     <= op_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ram_wren_q  <= ram_wren_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = (state_q == ST_RESP) && !owner_q;
  assign rsp1_valid = (state_q == ST_RESP) &&  owner_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign ram_wren   = ram_wren_q;

endmodule
